// File: rtl/sq_drain_ctrl.sv
// Store-queue drain controller: retires committed stores one at a time into the
// shared data-memory port, arbitrating against loads with a watermark and anti-starvation count.
module sq_drain_ctrl #(
    parameter int LSQ_SZ     = 8,
    parameter int N          = 3,
    parameter int HIGH_WM    = 6,
    parameter int STARVE_LIM = 4,
    localparam int RC_W  = $clog2(N + 1),
    localparam int IDX_W = $clog2(LSQ_SZ),
    localparam int CNT_W = $clog2(LSQ_SZ + 1),
    localparam int SV_W  = $clog2(STARVE_LIM + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [RC_W-1:0]  retire_count,
    input  logic             mispredict,
    output logic [IDX_W-1:0] head_idx,
    input  logic [31:0]      head_addr,
    input  logic [31:0]      head_data,
    input  logic             ld_req_valid,
    input  logic [31:0]      ld_req_addr,
    output logic             ld_grant,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic             mem_req_cmd,
    output logic [31:0]      mem_req_addr,
    output logic [31:0]      mem_req_data,
    input  logic             mem_wr_ack,
    output logic [RC_W-1:0]  free_count,
    output logic [CNT_W-1:0] commit_cnt,
    output logic             err,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUED   = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HIGH_WM_C = CNT_W'(HIGH_WM);
    localparam logic [CNT_W:0]   LSQ_SZ_C  = (CNT_W + 1)'(LSQ_SZ);
    localparam logic [SV_W-1:0]  STARVE_C  = SV_W'(STARVE_LIM);

    state_t            state, state_nxt;
    logic [SV_W-1:0]   starve_cnt;
    logic              can_load, store_elig, store_win, ack, stray_ack;
    logic [CNT_W:0]    cnt_sum;

    assign dbg_state = state;

    // Handshake: a request transfers on any edge where mem_req_valid && mem_req_ready;
    // while valid && !ready the register contents are frozen (loads may still be squashed).
    always_comb begin
        can_load   = !mem_req_valid || mem_req_ready;
        store_elig = (state == IDLE) && (commit_cnt != '0);
        store_win  = can_load && store_elig &&
                     (!ld_req_valid || (commit_cnt >= HIGH_WM_C) || (starve_cnt >= STARVE_C));
        ld_grant   = can_load && ld_req_valid && !store_win && !mispredict;
        ack        = (state == WAIT_ACK) && mem_wr_ack;
        stray_ack  = (state != WAIT_ACK) && mem_wr_ack;
        cnt_sum    = {1'b0, commit_cnt} + (CNT_W + 1)'(retire_count) - (CNT_W + 1)'(ack);
        state_nxt  = state;
        case (state)
            IDLE:     if (store_win) state_nxt = ISSUED;
            ISSUED:   if (mem_req_valid && mem_req_ready) state_nxt = WAIT_ACK;
            WAIT_ACK: if (mem_wr_ack) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_req_valid <= 1'b0;
            mem_req_cmd   <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_data  <= '0;
        end else if (store_win) begin
            mem_req_valid <= 1'b1;
            mem_req_cmd   <= 1'b1;
            mem_req_addr  <= head_addr;
            mem_req_data  <= head_data;
        end else if (ld_grant) begin
            mem_req_valid <= 1'b1;
            mem_req_cmd   <= 1'b0;
            mem_req_addr  <= ld_req_addr;
            mem_req_data  <= '0;
        end else if (can_load || (mispredict && !mem_req_cmd)) begin
            // Squash drops only a stalled load; a stalled store is committed work.
            mem_req_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_idx   <= '0;
            commit_cnt <= '0;
            free_count <= '0;
            starve_cnt <= '0;
            err        <= 1'b0;
        end else begin
            free_count <= RC_W'(ack);
            if (ack) head_idx <= head_idx + IDX_W'(1);
            if (cnt_sum > LSQ_SZ_C) commit_cnt <= CNT_W'(LSQ_SZ);
            else                     commit_cnt <= cnt_sum[CNT_W-1:0];
            if ((cnt_sum > LSQ_SZ_C) || stray_ack) err <= 1'b1;
            if (store_win)
                starve_cnt <= '0;
            else if (store_elig && ld_grant && (starve_cnt < STARVE_C))
                starve_cnt <= starve_cnt + SV_W'(1);
        end
    end

endmodule

// File: tb/tb_sq_drain_ctrl.sv
// Directed bench for sq_drain_ctrl: hand-computed vectors plus an in-order store scoreboard
// fed from the memory-side handshake.
module tb_sq_drain_ctrl;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic        clock, reset;
    logic [1:0]  retire_count;
    logic        mispredict;
    logic [2:0]  head_idx;
    logic [31:0] head_addr, head_data;
    logic        ld_req_valid;
    logic [31:0] ld_req_addr;
    logic        ld_grant;
    logic        mem_req_valid, mem_req_ready, mem_req_cmd;
    logic [31:0] mem_req_addr, mem_req_data;
    logic        mem_wr_ack;
    logic [1:0]  free_count;
    logic [3:0]  commit_cnt;
    logic        err;
    logic [1:0]  dbg_state;

    logic [64:0] exp_q[$];
    int vectors = 0;
    int misses  = 0;
    int pulses  = 0;

    sq_drain_ctrl dut (
        .clock(clock), .reset(reset), .retire_count(retire_count), .mispredict(mispredict),
        .head_idx(head_idx), .head_addr(head_addr), .head_data(head_data),
        .ld_req_valid(ld_req_valid), .ld_req_addr(ld_req_addr), .ld_grant(ld_grant),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_cmd(mem_req_cmd),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_wr_ack(mem_wr_ack),
        .free_count(free_count), .commit_cnt(commit_cnt), .err(err), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // SQ contents as a fixed function of the slot index
    function automatic logic [31:0] sq_addr_of(input logic [2:0] i);
        return 32'h0000_1000 + {23'd0, i, 6'd0};
    endfunction
    function automatic logic [31:0] sq_data_of(input logic [2:0] i);
        return {8'hD0, 5'd0, i, 16'hBEEF};
    endfunction
    function automatic logic [64:0] st_exp(input logic [2:0] i);
        return {1'b1, sq_addr_of(i), sq_data_of(i)};
    endfunction

    assign head_addr = sq_addr_of(head_idx);
    assign head_data = sq_data_of(head_idx);

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        vectors++;
        if (obs !== exp) begin
            misses++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every store handshake must match the next expected store
    always @(negedge clock) begin
        if (reset && mem_req_valid && mem_req_ready && mem_req_cmd) begin
            if (exp_q.size() == 0) check("sb_unexpected_store", 65'(1), 65'(0));
            else check("sb_store", {mem_req_cmd, mem_req_addr, mem_req_data}, exp_q.pop_front());
        end
        if (reset && free_count != 2'd0) pulses++;
    end

    // driver tasks
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        retire_count  = 2'd0;
        mispredict    = 1'b0;
        ld_req_valid  = 1'b0;
        ld_req_addr   = 32'd0;
        mem_req_ready = 1'b1;
        mem_wr_ack    = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
    endtask

    task automatic wait_state(input logic [1:0] st, input string tag);
        int n = 0;
        while (dbg_state !== st && n < 20) begin
            cyc();
            n++;
        end
        check(tag, 65'(dbg_state), 65'(st));
    endtask

    task automatic drain(input int idx, input logic [3:0] exp_cnt, input logic [1:0] extra);
        wait_state(S_WAIT, "drain_state");
        check("drain_head", 65'(head_idx), 65'(idx));
        mem_wr_ack   = 1'b1;
        retire_count = extra;
        cyc();
        mem_wr_ack   = 1'b0;
        retire_count = 2'd0;
        check("free_pulse", 65'(free_count), 65'(1));
        check("head_next", 65'(head_idx), 65'((idx + 1) % 8));
        check("commit_after", 65'(commit_cnt), 65'(exp_cnt));
    endtask

    initial begin
        int grants;
        bit seen;
        int i;

        // reset state, checked while asserted and after release
        reset = 1'b0; retire_count = 2'd0; mispredict = 1'b0; ld_req_valid = 1'b0;
        ld_req_addr = 32'd0; mem_req_ready = 1'b1; mem_wr_ack = 1'b0;
        cyc(); cyc();
        check("rst_valid", 65'(mem_req_valid), 65'(0));
        check("rst_outs", 65'({ld_grant, free_count, head_idx, commit_cnt, err, mem_req_cmd}), 65'(0));
        reset = 1'b1;
        cyc();
        check("rst_rel_outs", 65'({mem_req_valid, ld_grant, free_count, head_idx, commit_cnt, err}), 65'(0));
        check("rst_rel_req", 65'({mem_req_addr, mem_req_data}), 65'(0));
        check("rst_rel_state", 65'(dbg_state), 65'(S_IDLE));

        // single store drain
        exp_q.push_back(st_exp(3'd0));
        retire_count = 2'd1;
        cyc();
        retire_count = 2'd0;
        check("one_cnt", 65'(commit_cnt), 65'(1));
        check("one_notyet", 65'(mem_req_valid), 65'(0));
        cyc();
        check("one_req", {mem_req_valid, mem_req_cmd, mem_req_addr, mem_req_data},
              {2'b11, sq_addr_of(3'd0), sq_data_of(3'd0)});
        cyc();
        check("one_waitack", 65'(dbg_state), 65'(S_WAIT));
        cyc();
        mem_wr_ack = 1'b1;
        cyc();
        mem_wr_ack = 1'b0;
        check("one_free", 65'(free_count), 65'(1));
        check("one_head", 65'(head_idx), 65'(1));
        check("one_cnt0", 65'(commit_cnt), 65'(0));
        cyc();
        check("one_free_off", 65'(free_count), 65'(0));

        // wrap: 9 stores through 8 slots, commit reaches exactly LSQ_SZ without error
        do_reset();
        pulses = 0;
        for (int k = 0; k < 9; k++) exp_q.push_back(st_exp(3'(k % 8)));
        retire_count = 2'd3; cyc();
        retire_count = 2'd3; cyc();
        retire_count = 2'd2; cyc();
        retire_count = 2'd0;
        check("wrap_full", 65'(commit_cnt), 65'(8));
        check("wrap_noerr", 65'(err), 65'(0));
        drain(0, 4'd8, 2'd1);
        for (int k = 1; k < 9; k++) drain(k % 8, 4'(8 - k), 2'd0);
        cyc();
        check("wrap_pulses", 65'(pulses), 65'(9));
        check("wrap_err", 65'(err), 65'(0));

        // starvation: commit_cnt=2, loads continuously requesting
        do_reset();
        exp_q.push_back(st_exp(3'd0));
        exp_q.push_back(st_exp(3'd1));
        retire_count = 2'd2;
        cyc();
        retire_count = 2'd0;
        ld_req_valid = 1'b1;
        grants = 0; seen = 1'b0; i = 0;
        while (!seen && i < 12) begin
            ld_req_addr = 32'hA000_0000 + 32'(i * 16);
            #1;
            if (mem_req_valid && mem_req_cmd) seen = 1'b1;
            else grants += int'(ld_grant);
            if (i == 1)
                check("starve_ld_req", {mem_req_valid, mem_req_cmd, mem_req_addr, mem_req_data},
                      {2'b10, 32'hA000_0000, 32'd0});
            if (!seen) begin
                cyc();
                i++;
            end
        end
        check("starve_store_seen", 65'(seen), 65'(1));
        check("starve_grants", 65'(grants), 65'(4));
        check("starve_store_addr", 65'(mem_req_addr), 65'(sq_addr_of(3'd0)));
        ld_req_valid = 1'b0;
        drain(0, 4'd1, 2'd0);
        drain(1, 4'd0, 2'd0);

        // high watermark: store wins as soon as commit_cnt reaches 6
        do_reset();
        exp_q.push_back(st_exp(3'd0));
        retire_count = 2'd3; ld_req_valid = 1'b1; ld_req_addr = 32'hC000_0000;
        #1 check("wm_grant_a", 65'(ld_grant), 65'(1));
        cyc();
        retire_count = 2'd3;
        #1 check("wm_grant_b", 65'(ld_grant), 65'(1));
        cyc();
        retire_count = 2'd0;
        check("wm_cnt6", 65'(commit_cnt), 65'(6));
        #1 check("wm_no_grant", 65'(ld_grant), 65'(0));
        cyc();
        ld_req_valid = 1'b0;
        check("wm_store", {mem_req_valid, mem_req_cmd, mem_req_addr}, {2'b11, sq_addr_of(3'd0)});
        cyc();

        // overflow: 3+3+3 saturates at 8 and raises err
        do_reset();
        mem_req_ready = 1'b0;
        retire_count = 2'd3; cyc();
        retire_count = 2'd3; cyc();
        retire_count = 2'd3; cyc();
        retire_count = 2'd0;
        check("ovf_sat", 65'(commit_cnt), 65'(8));
        check("ovf_err", 65'(err), 65'(1));

        // backpressure, then squash of a stalled load
        do_reset();
        mem_req_ready = 1'b0;
        exp_q.push_back(st_exp(3'd0));
        retire_count = 2'd1; cyc();
        retire_count = 2'd0; cyc();
        check("bp_store", {mem_req_valid, mem_req_cmd, mem_req_addr, mem_req_data},
              {2'b11, sq_addr_of(3'd0), sq_data_of(3'd0)});
        ld_req_valid = 1'b1; ld_req_addr = 32'hB000_0000;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_stable", {mem_req_valid, mem_req_cmd, mem_req_addr, mem_req_data},
                  {2'b11, sq_addr_of(3'd0), sq_data_of(3'd0)});
            check("bp_no_grant", 65'(ld_grant), 65'(0));
            cyc();
        end
        mem_req_ready = 1'b1;
        #1 check("bp_hs_grant", 65'(ld_grant), 65'(1));
        cyc();
        mem_req_ready = 1'b0; ld_req_valid = 1'b0; mispredict = 1'b1;
        check("mp_ld_loaded", {mem_req_valid, mem_req_cmd, mem_req_addr, mem_req_data},
              {2'b10, 32'hB000_0000, 32'd0});
        cyc();
        mispredict = 1'b0;
        check("mp_ld_dropped", 65'(mem_req_valid), 65'(0));
        check("mp_state", 65'(dbg_state), 65'(S_WAIT));
        check("mp_cnt", 65'(commit_cnt), 65'(1));
        ld_req_valid = 1'b1; mispredict = 1'b1;
        #1 check("mp_grant_low", 65'(ld_grant), 65'(0));
        cyc();
        mispredict = 1'b0; ld_req_valid = 1'b0;
        check("mp_still_empty", 65'(mem_req_valid), 65'(0));
        mem_wr_ack = 1'b1;
        cyc();
        mem_wr_ack = 1'b0;
        check("bp_free", 65'(free_count), 65'(1));
        check("bp_head", 65'({head_idx, commit_cnt}), 65'({3'd1, 4'd0}));

        // squash with a stalled store: store must survive
        do_reset();
        mem_req_ready = 1'b0;
        exp_q.push_back(st_exp(3'd0));
        retire_count = 2'd1; cyc();
        retire_count = 2'd0; cyc();
        mispredict = 1'b1;
        cyc();
        mispredict = 1'b0;
        check("mp_store_kept", {mem_req_valid, mem_req_cmd, mem_req_addr},
              {2'b11, sq_addr_of(3'd0)});
        mem_req_ready = 1'b1;
        drain(0, 4'd0, 2'd0);

        // stray ack in IDLE: sticky err, no side effects
        cyc();
        check("stray_idle", 65'(dbg_state), 65'(S_IDLE));
        mem_wr_ack = 1'b1;
        cyc();
        mem_wr_ack = 1'b0;
        check("stray_err", 65'(err), 65'(1));
        check("stray_side", 65'({head_idx, commit_cnt, free_count}), 65'({3'd1, 4'd0, 2'd0}));
        cyc(); cyc(); cyc();
        check("stray_sticky", 65'(err), 65'(1));
        do_reset();
        check("stray_cleared", 65'(err), 65'(0));

        check("sb_drained", 65'(exp_q.size()), 65'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule

// File: doc/sq_drain_ctrl.md
Name: sq_drain_ctrl

Overview:
- Sequences retirement of committed stores from the store queue into the single data-memory port, and shares that port with the load unit.
- Tracks the committed-but-undrained store count and the SQ head index, and issues one store write at a time.
- Arbitrates the port between stores and loads using a watermark and an anti-starvation counter.
- Returns freed SQ slots to the store queue via free_count.

Parameters:
- LSQ_SZ, 8, store queue depth (power of two).
- N, 3, superscalar retire width.
- HIGH_WM, 6, commit_cnt at or above which stores beat loads.
- STARVE_LIM, 4, consecutive load wins while a store is eligible before the store is forced.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- retire_count  in  $clog2(N+1)  stores committed by the ROB this cycle.
- mispredict  in  1  branch squash.
- head_idx  out  $clog2(LSQ_SZ)  SQ index of the oldest committed store.
- head_addr  in  32  address of SQ[head_idx].
- head_data  in  32  data of SQ[head_idx].
- ld_req_valid  in  1  load unit requests the port.
- ld_req_addr  in  32  load address.
- ld_grant  out  1  load captured into the request register this cycle.
- mem_req_valid  out  1  request register valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_cmd  out  1  0 = load, 1 = store.
- mem_req_addr  out  32  request address.
- mem_req_data  out  32  store data (0 for loads).
- mem_wr_ack  in  1  store write completed.
- free_count  out  $clog2(N+1)  SQ entries released this cycle (0 or 1).
- commit_cnt  out  $clog2(LSQ_SZ+1)  committed, undrained stores.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (reset=0, async): all outputs are 0, including mem_req_valid, ld_grant, free_count, head_idx, commit_cnt and err. The request register is cleared, the FSM goes to IDLE, and starve_cnt is 0.
- Store FSM states:
  - IDLE: no store outstanding.
  - ISSUED: store is in the request register, awaiting handshake.
  - WAIT_ACK: store is handshaken, awaiting mem_wr_ack.
- Store FSM transitions:
  - IDLE → ISSUED when the store wins arbitration.
  - ISSUED → WAIT_ACK on mem_req_valid && mem_req_ready.
  - WAIT_ACK → IDLE on mem_wr_ack.
- Only one store is outstanding at a time. Loads may still issue during ISSUED (after handshake) and WAIT_ACK.
- The request register may load on an edge if it is empty or is handshaking that cycle (mem_req_valid && mem_req_ready). Contents are held stable while valid and not ready.
- Store eligibility: state == IDLE && commit_cnt > 0.
- Arbitration, evaluated when the register may load:
  - Store wins if eligible and any of: !ld_req_valid, commit_cnt >= HIGH_WM, or starve_cnt >= STARVE_LIM.
  - Otherwise a present load wins.
  - ld_grant is combinational, high exactly in cycles where the load is captured at the coming edge.
- starve_cnt:
  - Increments, saturating at STARVE_LIM, on an edge where a store is eligible and a load is captured.
  - Clears when a store is captured.
- Store payload is head_addr/head_data sampled at the capture edge, with cmd=1.
- Latency:
  - retire_count > 0 in cycle t, no load, IDLE → mem_req_valid high in cycle t+2.
  - ld_req_valid with a free register in cycle t → ld_grant in cycle t, mem_req_valid in cycle t+1.
- mem_wr_ack in WAIT_ACK, cycle t:
  - At the edge: head_idx increments mod LSQ_SZ (wraps LSQ_SZ-1 → 0) and commit_cnt decrements.
  - free_count = 1 for cycle t+1 only.
- commit_cnt next value = commit_cnt + retire_count − (ack ? 1 : 0); a simultaneous retire and ack is legal.
- If the sum exceeds LSQ_SZ, commit_cnt saturates at LSQ_SZ and err is set.
- mem_wr_ack outside WAIT_ACK is ignored and sets err.
- mispredict:
  - Committed stores, FSM state, commit_cnt and head_idx are unaffected.
  - A load in the request register that is not handshaken that cycle is dropped: mem_req_valid = 0 next cycle.
  - A store in the register is never dropped.
  - ld_grant is forced low during a mispredict cycle.
- Reset mid-operation: any outstanding request or ack wait is abandoned immediately. The environment must not deliver a stale ack afterwards; if it does, err is set.

Test Plan:
- Reset: hold reset=0 for 2 cycles, release → all outputs 0, head_idx=0, commit_cnt=0.
- Single store drain: retire_count=1 at cycle 0, mem_req_ready=1, ack 2 cycles after handshake.
  - mem_req_valid=1, cmd=1 at cycle 2, with addr/data equal to head SQ[0].
  - free_count=1 exactly one cycle after the ack; head_idx=1; commit_cnt=0.
- Wrap: drain 9 stores through LSQ_SZ=8 → head_idx sequence 0..7,0,1; free_count pulses exactly 9 times.
- Load priority and starvation: commit_cnt=2, ld_req_valid held high.
  - Exactly 4 ld_grants, then the store issues on the 5th opportunity.
  - Repeat with commit_cnt=6 → the store issues immediately.
- Backpressure: mem_req_ready=0 for 5 cycles with a store pending → addr/data/cmd stay stable, no new ld_grant; the handshake happens when ready rises.
- Mispredict and error:
  - Load pending with ready=0 plus a mispredict pulse → mem_req_valid=0 next cycle.
  - Store pending plus mispredict → the store remains.
  - Stray mem_wr_ack in IDLE → err=1, sticky until reset.
